// File: rtl/issue_pkg.sv
// Shared types and defaults for the issue hazard sequencer.
// Holds the bundle progress state and default lane/register widths.
package issue_pkg;

   typedef enum logic {
      FRESH = 1'b0,
      SPLIT = 1'b1
   } state_e;

   localparam int unsigned DEF_LANES = 2;
   localparam int unsigned DEF_REG_W = 5;

endpackage

// File: rtl/lane_hazard_cmp.sv
// Dependency check between an older lane j and a younger lane k.
// Covers RAW on either source and WAW; x0 never creates a hazard.
module lane_hazard_cmp #(
   parameter int unsigned REG_W = 5
) (
   input  logic             we_j_i,
   input  logic [REG_W-1:0] rd_j_i,
   input  logic             we_k_i,
   input  logic [REG_W-1:0] rd_k_i,
   input  logic [REG_W-1:0] rs1_k_i,
   input  logic [REG_W-1:0] rs2_k_i,
   output logic             hazard_o
);

   logic raw;
   logic waw;

   assign raw = (rd_j_i == rs1_k_i) || (rd_j_i == rs2_k_i);
   assign waw = we_k_i && (rd_k_i == rd_j_i);

   assign hazard_o = we_j_i && (rd_j_i != '0) && (raw || waw);

endmodule

// File: rtl/issue_hazard_sequencer.sv
// Splits a decode bundle into in-order issue groups around intra-bundle
// register dependencies, tracking partially issued bundles across cycles.
module issue_hazard_sequencer
   import issue_pkg::*;
#(
   parameter int unsigned LANES = DEF_LANES,
   parameter int unsigned REG_W = DEF_REG_W,
   parameter int unsigned CNT_W = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        bundle_valid_i,
   input  logic [LANES-1:0]            lane_valid_i,
   input  logic [LANES-1:0][REG_W-1:0] rd_i,
   input  logic [LANES-1:0][REG_W-1:0] rs1_i,
   input  logic [LANES-1:0][REG_W-1:0] rs2_i,
   input  logic [LANES-1:0]            rd_we_i,
   input  logic                        ds_stall_i,
   input  logic                        flush_i,
   output logic [LANES-1:0]            issue_o,
   output logic                        bundle_done_o,
   output logic                        stall_fd_o,
   output logic                        split_o,
   output logic [CNT_W-1:0]            split_cnt_o
);

   state_e           state_q;
   logic [LANES-1:0] issued_q;
   logic [LANES-1:0] issued_d;
   logic [CNT_W-1:0] split_cnt_q;
   logic [LANES-1:0] remaining;
   logic [LANES-1:0] issue_raw;
   logic             go;
   logic             cnt_inc;
   logic             haz [LANES][LANES];

   for (genvar j = 0; j < LANES; j++) begin : g_j
      for (genvar k = 0; k < LANES; k++) begin : g_k
         if (j < k) begin : g_cmp
            lane_hazard_cmp #(
               .REG_W(REG_W)
            ) u_cmp (
               .we_j_i  (rd_we_i[j]),
               .rd_j_i  (rd_i[j]),
               .we_k_i  (rd_we_i[k]),
               .rd_k_i  (rd_i[k]),
               .rs1_k_i (rs1_i[k]),
               .rs2_k_i (rs2_i[k]),
               .hazard_o(haz[j][k])
            );
         end else begin : g_none
            assign haz[j][k] = 1'b0;
         end
      end
   end

   assign remaining = bundle_valid_i ? (lane_valid_i & ~issued_q) : '0;

   // Once a remaining lane is held back, every younger lane is held too.
   always_comb begin
      logic cand;
      logic blk;
      issue_raw = '0;
      cand      = 1'b1;
      blk       = 1'b0;
      for (int k = 0; k < LANES; k++) begin
         blk = 1'b0;
         for (int j = 0; j < k; j++) begin
            blk = blk | (remaining[j] & haz[j][k]);
         end
         if (remaining[k]) begin
            if (cand && !blk) issue_raw[k] = 1'b1;
            else              cand = 1'b0;
         end
      end
   end

   assign go      = !rst && !ds_stall_i && !flush_i;
   assign issue_o = go ? issue_raw : '0;

   assign bundle_done_o = bundle_valid_i && go &&
                          ((remaining & ~issue_o) == '0);
   assign stall_fd_o    = !rst && bundle_valid_i &&
                          !bundle_done_o && !flush_i;

   assign cnt_inc = (|issue_o) && !bundle_done_o;

   always_comb begin
      issued_d = issued_q | issue_o;
      if (flush_i || bundle_done_o) issued_d = '0;
      else if (ds_stall_i)          issued_d = issued_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FRESH;
         issued_q    <= '0;
         split_cnt_q <= '0;
      end else begin
         issued_q <= issued_d;
         if (cnt_inc && !(&split_cnt_q))
            split_cnt_q <= split_cnt_q + 1'b1;
         unique case (state_q)
            FRESH: if (cnt_inc) state_q <= SPLIT;
            SPLIT: if (bundle_done_o || flush_i) state_q <= FRESH;
         endcase
      end
   end

   assign split_o     = (state_q == SPLIT);
   assign split_cnt_o = split_cnt_q;

endmodule

// File: tb/tb_issue_hazard_sequencer.sv
// Directed and randomized checks of the issue hazard sequencer
// against a lane-group reference model.
module tb_issue_hazard_sequencer;

   logic             clk;
   logic             rst;
   logic             bv;
   logic [3:0]       lv;
   logic [3:0][4:0]  rd;
   logic [3:0][4:0]  rs1;
   logic [3:0][4:0]  rs2;
   logic [3:0]       we;
   logic             ds;
   logic             fl;

   logic [3:0]       issue_o;
   logic             done_o;
   logic             stall_o;
   logic             split_o;
   logic [7:0]       cnt_o;

   logic [1:0]       s_issue_o;
   logic             s_done_o;
   logic             s_stall_o;
   logic             s_split_o;
   logic [1:0]       s_cnt_o;

   int n_chk;
   int n_err;

   logic [3:0] m_issued;
   int         m_cnt;
   logic [3:0] e_issue;
   logic       e_done;
   logic       e_stall;

   issue_hazard_sequencer #(
      .LANES(4), .REG_W(5), .CNT_W(8)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .bundle_valid_i(bv),
      .lane_valid_i  (lv),
      .rd_i          (rd),
      .rs1_i         (rs1),
      .rs2_i         (rs2),
      .rd_we_i       (we),
      .ds_stall_i    (ds),
      .flush_i       (fl),
      .issue_o       (issue_o),
      .bundle_done_o (done_o),
      .stall_fd_o    (stall_o),
      .split_o       (split_o),
      .split_cnt_o   (cnt_o)
   );

   issue_hazard_sequencer #(
      .LANES(2), .REG_W(5), .CNT_W(2)
   ) u_sat (
      .clk           (clk),
      .rst           (rst),
      .bundle_valid_i(bv),
      .lane_valid_i  (lv[1:0]),
      .rd_i          (rd[1:0]),
      .rs1_i         (rs1[1:0]),
      .rs2_i         (rs2[1:0]),
      .rd_we_i       (we[1:0]),
      .ds_stall_i    (ds),
      .flush_i       (fl),
      .issue_o       (s_issue_o),
      .bundle_done_o (s_done_o),
      .stall_fd_o    (s_stall_o),
      .split_o       (s_split_o),
      .split_cnt_o   (s_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit dep(int j, int k);
      if (!we[j] || rd[j] == 0) return 0;
      if (rd[j] == rs1[k] || rd[j] == rs2[k]) return 1;
      return we[k] && rd[k] == rd[j];
   endfunction

   // Issue the longest in-order run of remaining lanes with no
   // dependency on any earlier member of the run.
   function automatic logic [3:0] model_group(logic [3:0] rem);
      int grp[$];
      logic [3:0] r;
      bit stop;
      r    = '0;
      stop = 0;
      for (int k = 0; k < 4; k++) begin
         if (rem[k] && !stop) begin
            foreach (grp[i]) if (dep(grp[i], k)) stop = 1;
            if (!stop) grp.push_back(k);
         end
      end
      foreach (grp[i]) r[grp[i]] = 1'b1;
      return r;
   endfunction

   task automatic eval();
      logic [3:0] rem;
      bit go;
      #1;
      rem     = bv ? (lv & ~m_issued) : 4'b0;
      go      = !rst && !ds && !fl;
      e_issue = go ? model_group(rem) : 4'b0;
      e_done  = bv && go && ((rem & ~e_issue) == 0);
      e_stall = !rst && bv && !e_done && !fl;
      chk("issue", issue_o, e_issue);
      chk("done", done_o, e_done);
      chk("stall", stall_o, e_stall);
      chk("split", split_o, m_issued != 0);
      chk("cnt", cnt_o, (m_cnt > 255) ? 255 : m_cnt);
   endtask

   task automatic tick();
      if (rst) begin
         m_issued = '0;
         m_cnt    = 0;
      end else begin
         if (e_issue != 0 && !e_done) m_cnt++;
         if (fl || e_done) m_issued = '0;
         else if (!ds)     m_issued = m_issued | e_issue;
      end
      @(negedge clk);
   endtask

   task automatic clr();
      bv = 0; lv = '0; we = '0; ds = 0; fl = 0;
      rd = '0; rs1 = '0; rs2 = '0;
   endtask

   task automatic lane(int l, logic [4:0] d, logic [4:0] a,
                       logic [4:0] b, logic w);
      lv[l]  = 1'b1;
      rd[l]  = d;
      rs1[l] = a;
      rs2[l] = b;
      we[l]  = w;
   endtask

   task automatic raw_bundle();
      clr();
      bv = 1;
      lane(0, 5'd5, 5'd0, 5'd0, 1);
      lane(1, 5'd6, 5'd5, 5'd0, 1);
   endtask

   task automatic indep_bundle();
      clr();
      bv = 1;
      lane(0, 5'd5, 5'd0, 5'd0, 1);
      lane(1, 5'd6, 5'd1, 5'd2, 1);
   endtask

   initial begin
      n_chk = 0; n_err = 0;
      m_issued = '0; m_cnt = 0;
      e_issue = '0; e_done = 0; e_stall = 0;
      clr();
      rst = 1;
      @(negedge clk);
      eval();
      chk("rst_issue", issue_o, 0);
      chk("rst_stall", stall_o, 0);
      tick();
      rst = 0;
      eval();
      chk("rst_cnt", cnt_o, 0);
      chk("rst_split", split_o, 0);
      tick();

      indep_bundle();
      eval();
      chk("indep_issue", issue_o, 4'b0011);
      chk("indep_done", done_o, 1);
      tick();
      clr();
      eval();
      chk("indep_cnt", cnt_o, 0);
      tick();

      for (int v = 0; v < 3; v++) begin
         raw_bundle();
         if (v == 1) begin
            rd[0] = 5'd7; rd[1] = 5'd7; rs1[1] = 5'd0;
         end
         if (v == 2) begin
            rd[0] = 5'd0; rd[1] = 5'd0; rs1[1] = 5'd0;
         end
         eval();
         if (v == 2) begin
            chk("x0_issue", issue_o, 4'b0011);
            chk("x0_done", done_o, 1);
         end else begin
            chk("dep_c0_issue", issue_o, 4'b0001);
            chk("dep_c0_stall", stall_o, 1);
            tick();
            eval();
            chk("dep_c1_split", split_o, 1);
            chk("dep_c1_cnt", cnt_o, v + 1);
            chk("dep_c1_issue", issue_o, 4'b0010);
            chk("dep_c1_done", done_o, 1);
         end
         tick();
         clr();
         eval();
         chk("dep_after_split", split_o, 0);
         tick();
      end

      raw_bundle();
      eval();
      tick();
      ds = 1;
      for (int i = 0; i < 3; i++) begin
         eval();
         chk("ds_issue", issue_o, 0);
         chk("ds_split", split_o, 1);
         chk("ds_cnt", cnt_o, 3);
         tick();
      end
      ds = 0;
      eval();
      chk("ds_rel_issue", issue_o, 4'b0010);
      chk("ds_rel_done", done_o, 1);
      tick();

      clr();
      bv = 1;
      lane(0, 5'd9, 5'd0, 5'd0, 1);
      lane(1, 5'd10, 5'd1, 5'd2, 1);
      lane(2, 5'd11, 5'd0, 5'd9, 1);
      lane(3, 5'd12, 5'd3, 5'd4, 1);
      eval();
      chk("l4_c0_issue", issue_o, 4'b0011);
      tick();
      eval();
      chk("l4_c1_issue", issue_o, 4'b1100);
      chk("l4_c1_done", done_o, 1);
      chk("l4_c1_cnt", cnt_o, 4);
      tick();

      raw_bundle();
      eval();
      tick();
      fl = 1;
      eval();
      chk("fl_issue", issue_o, 0);
      chk("fl_done", done_o, 0);
      tick();
      indep_bundle();
      eval();
      chk("fl_split", split_o, 0);
      chk("fl_new_issue", issue_o, 4'b0011);
      tick();

      raw_bundle();
      eval();
      tick();
      rst = 1;
      eval();
      chk("rs_issue", issue_o, 0);
      tick();
      rst = 0;
      indep_bundle();
      eval();
      chk("rs_split", split_o, 0);
      chk("rs_cnt", cnt_o, 0);
      chk("rs_new_issue", issue_o, 4'b0011);
      tick();

      for (int b = 0; b < 4; b++) begin
         raw_bundle();
         eval();
         tick();
         eval();
         chk("sat_cnt", s_cnt_o, (b < 3) ? b + 1 : 3);
         tick();
      end

      clr();
      for (int c = 0; c < 3000; c++) begin
         if (!e_stall) begin
            bv = ($urandom % 5) != 0;
            for (int l = 0; l < 4; l++) begin
               lv[l]  = $urandom % 4 != 0;
               we[l]  = $urandom % 3 != 0;
               rd[l]  = 5'($urandom_range(0, 7));
               rs1[l] = 5'($urandom_range(0, 7));
               rs2[l] = 5'($urandom_range(0, 7));
            end
         end
         ds  = ($urandom % 4) == 0;
         fl  = ($urandom % 16) == 0;
         rst = ($urandom % 64) == 0;
         eval();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
